// File: rtl/fp_normalize_pipe.sv
// rtl/fp_normalize_pipe.sv - two-stage floating-point normaliser with valid/ready handshake
// Stage 1 captures the operand and leading-zero count; stage 2 forms the packed result and flags.
module fp_normalize_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+1:0]       M,
  input  logic [EXP_W-1:0]       E,
  input  logic                   S,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Z,
  output logic                   OF,
  output logic                   UF,
  output logic                   ZR
);
  localparam int LW = $clog2(MAN_W + 2);
  localparam int CW = ((EXP_W > LW) ? EXP_W : LW) + 1;
  localparam logic [CW-1:0] C_EXP_MAX = {{(CW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

  logic              w_advance;
  logic [LW-1:0]     w_lzc;

  logic              r1_valid;
  logic              r1_carry;
  logic [MAN_W:0]    r1_m;
  logic [EXP_W-1:0]  r1_e;
  logic              r1_s;
  logic [LW-1:0]     r1_l;

  logic              r2_valid;
  logic [EXP_W+MAN_W:0] r2_z;
  logic              r2_of;
  logic              r2_uf;
  logic              r2_zr;

  logic [CW-1:0]     w_e_ext;
  logic [CW-1:0]     w_l_ext;
  logic [CW-1:0]     w_exp;
  logic [MAN_W-1:0]  w_shifted;
  logic [MAN_W-1:0]  w_frac;
  logic              w_m_zero;
  logic              w_under;
  logic              w_over;
  logic [EXP_W+MAN_W:0] w_z;
  logic              w_of;
  logic              w_uf;
  logic              w_zr;

  assign w_advance = !r2_valid | out_ready;
  // Reset forces readiness so upstream never stalls while the pipe is being cleared.
  assign in_ready  = w_advance | RST;

  always_comb begin
    w_lzc = LW'(MAN_W + 1);
    for (int i = 0; i <= MAN_W; i++) begin
      if (M[i]) w_lzc = LW'(MAN_W - i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_valid <= 1'b0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      r1_carry <= M[MAN_W+1];
      r1_m     <= M[MAN_W:0];
      r1_e     <= E;
      r1_s     <= S;
      r1_l     <= w_lzc;
    end
  end

  assign w_e_ext   = CW'(r1_e);
  assign w_l_ext   = CW'(r1_l);
  assign w_shifted = MAN_W'(r1_m << r1_l);
  assign w_m_zero  = !r1_carry && (r1_m == '0);
  assign w_under   = !r1_carry && (w_l_ext >= w_e_ext);

  always_comb begin
    if (r1_carry) begin
      w_exp  = w_e_ext + CW'(1);
      w_frac = r1_m[MAN_W:1];
    end else begin
      w_exp  = w_e_ext - w_l_ext;
      w_frac = w_shifted;
    end
  end

  // An all-ones input exponent overflows even when the shifted exponent would underflow.
  assign w_over = (&r1_e) || (!w_under && (w_exp >= C_EXP_MAX));

  always_comb begin
    w_z  = {r1_s, w_exp[EXP_W-1:0], w_frac};
    w_of = 1'b0;
    w_uf = 1'b0;
    w_zr = 1'b0;
    if (w_m_zero) begin
      w_z  = {r1_s, {(EXP_W+MAN_W){1'b0}}};
      w_zr = 1'b1;
    end else if (w_over) begin
      w_z  = {r1_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_of = 1'b1;
    end else if (w_under) begin
      w_z  = {r1_s, {(EXP_W+MAN_W){1'b0}}};
      w_uf = 1'b1;
      w_zr = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r2_valid <= 1'b0;
      r2_z     <= '0;
      r2_of    <= 1'b0;
      r2_uf    <= 1'b0;
      r2_zr    <= 1'b0;
    end else if (w_advance) begin
      r2_valid <= r1_valid;
      r2_z     <= w_z;
      r2_of    <= w_of;
      r2_uf    <= w_uf;
      r2_zr    <= w_zr;
    end
  end

  assign out_valid = r2_valid;
  assign Z         = r2_z;
  assign OF        = r2_of;
  assign UF        = r2_uf;
  assign ZR        = r2_zr;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb/tb_fp_normalize_pipe.sv - scoreboard bench for fp_normalize_pipe
module tb_fp_normalize_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic [MAN_W+1:0] M;
  logic [EXP_W-1:0] E;
  logic             S;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     Z;
  logic             OF;
  logic             UF;
  logic             ZR;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [W+2:0] exp_q[$];

  typedef struct {
    logic [MAN_W+1:0] m;
    logic [EXP_W-1:0] e;
    logic             s;
    logic [W+2:0]     x;
  } vec_t;

  vec_t vecs[15];

  always #5 CLK = ~CLK;

  fp_normalize_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .M(M), .E(E), .S(S), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .OF(OF), .UF(UF), .ZR(ZR)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [MAN_W+1:0] m, input logic [EXP_W-1:0] e, input logic s,
                      input logic [W+2:0] x, input bit track);
    int n = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    M = m;
    E = e;
    S = s;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept_within_20");
    end else if (track) begin
      exp_q.push_back(x);
      pushed++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  logic         hold_v = 1'b0;
  logic [W+2:0] hold_val;

  always @(negedge CLK) begin
    #2;
    if (RST) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {out_valid, Z, OF, UF, ZR}, {1'b1, hold_val});
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output actual=%h required=none", {Z, OF, UF, ZR});
        end else begin
          chk("result", {Z, OF, UF, ZR}, exp_q.pop_front());
          popped++;
        end
      end else if (out_valid) begin
        hold_v   = 1'b1;
        hold_val = {Z, OF, UF, ZR};
      end
    end
  end

  initial begin
    vecs[0]  = '{25'h0800000, 8'h7F, 1'b0, {32'h3F800000, 3'b000}};
    vecs[1]  = '{25'h1000000, 8'h7F, 1'b0, {32'h40000000, 3'b000}};
    vecs[2]  = '{25'h1000000, 8'hFE, 1'b0, {32'h7F800000, 3'b100}};
    vecs[3]  = '{25'h0000001, 8'h7F, 1'b0, {32'h34000000, 3'b000}};
    vecs[4]  = '{25'h0000001, 8'h10, 1'b1, {32'h80000000, 3'b011}};
    vecs[5]  = '{25'h0000000, 8'h55, 1'b1, {32'h80000000, 3'b001}};
    vecs[6]  = '{25'h0C00000, 8'h80, 1'b1, {32'hC0400000, 3'b000}};
    vecs[7]  = '{25'h0000003, 8'h7F, 1'b0, {32'h34C00000, 3'b000}};
    vecs[8]  = '{25'h1800001, 8'h7F, 1'b0, {32'h40400000, 3'b000}};
    vecs[9]  = '{25'h0800000, 8'hFF, 1'b0, {32'h7F800000, 3'b100}};
    vecs[10] = '{25'h0400000, 8'h01, 1'b0, {32'h00000000, 3'b011}};
    vecs[11] = '{25'h0400000, 8'h02, 1'b0, {32'h00800000, 3'b000}};
    vecs[12] = '{25'h0000000, 8'hFF, 1'b0, {32'h00000000, 3'b001}};
    vecs[13] = '{25'h1000000, 8'hFF, 1'b1, {32'hFF800000, 3'b100}};
    vecs[14] = '{25'h1000000, 8'hFD, 1'b0, {32'h7F000000, 3'b000}};

    in_valid  = 1'b0;
    M         = '0;
    E         = '0;
    S         = 1'b0;
    out_ready = 1'b1;
    RST       = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("in_ready_in_reset", in_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_z", Z, 0);
    chk("reset_flags", {OF, UF, ZR}, 0);
    chk("in_ready_after_reset", in_ready, 1);

    foreach (vecs[i]) send(vecs[i].m, vecs[i].e, vecs[i].s, vecs[i].x, 1'b1);
    idle();
    drain();

    out_ready = 1'b0;
    fork
      begin
        send(25'h0800000, 8'h7F, 1'b0, {32'h3F800000, 3'b000}, 1'b1);
        send(25'h0C00000, 8'h80, 1'b1, {32'hC0400000, 3'b000}, 1'b1);
        send(25'h0000003, 8'h7F, 1'b0, {32'h34C00000, 3'b000}, 1'b1);
        idle();
      end
      begin
        repeat (3) @(negedge CLK);
        #1;
        chk("in_ready_low_when_full", in_ready, 0);
        @(negedge CLK);
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(25'h0800000, 8'h7F, 1'b0, '0, 1'b0);
    send(25'h1000000, 8'h7F, 1'b0, '0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("in_ready_mid_reset", in_ready, 1);
    @(negedge CLK);
    #1;
    chk("flush_out_valid", out_valid, 0);
    RST = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge CLK);
    #3;
    chk("flush_no_output", out_valid, 0);

    send(25'h0000001, 8'h7F, 1'b0, {32'h34000000, 3'b000}, 1'b1);
    idle();
    drain();
    chk("delivered_count", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize_pipe.md
FP_NORMALIZE_PIPE -- requirements
Module: fp_normalize_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; packed result width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have one clock, CLK (input, 1), and synchronous active-high reset, RST (input, 1); all state updates on rising CLK.
REQ-004 SHALL have in_valid, input, 1: an operand is presented.
REQ-005 SHALL have in_ready, output, 1: the operand is accepted this cycle.
REQ-006 SHALL have M, input, MAN_W+2: unnormalised mantissa; M[MAN_W+1] is the carry bit, M[MAN_W] the hidden-bit position.
REQ-007 SHALL have E, input, EXP_W: biased exponent before normalisation.
REQ-008 SHALL have S, input, 1: sign.
REQ-009 SHALL have out_valid, output, 1: Z and flags are valid.
REQ-010 SHALL have out_ready, input, 1: the downstream stage accepts Z.
REQ-011 SHALL have Z, output, W: {sign, exponent, fraction}.
REQ-012 SHALL have OF, output, 1: overflow; Z is infinity.
REQ-013 SHALL have UF, output, 1: underflow; Z is flushed to zero.
REQ-014 SHALL have ZR, output, 1: result is zero (UF or zero mantissa).

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers the operand, carry flag and leading-zero count L of M[MAN_W:0]; stage 2 registers Z and the flags.
REQ-016 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high, with throughput of 1 operand/cycle.
REQ-017 SHALL define advance = !out_valid | out_ready; in_ready = advance; no stage register changes while advance = 0.
REQ-018 SHALL accept an operand on in_valid & in_ready; a stage-1 bubble SHALL propagate as out_valid = 0.
REQ-019 SHALL, when M[MAN_W+1] = 1, compute exponent E+1 (EXP_W+1-bit arithmetic) and fraction M[MAN_W:1], with the LSB truncated and no rounding.
REQ-020 SHALL, when M[MAN_W+1] = 0 and M != 0, compute exponent E-L and fraction = (M[MAN_W:0] << L)[MAN_W-1:0].
REQ-021 SHALL, when M = 0, output {S, 0, 0} with ZR = 1 and UF = 0.
REQ-022 SHALL, when M[MAN_W+1] = 0, M != 0 and L >= E, output {S, 0, 0} with UF = 1 and ZR = 1 (no denormals).
REQ-023 SHALL, when the computed exponent is >= 2^EXP_W-1 or the input E is all ones, output {S, all-ones, 0} with OF = 1.
REQ-024 SHALL give the zero-mantissa check priority over the overflow check, and the overflow check priority over the underflow check.
REQ-025 SHALL hold Z, OF, UF and ZR stable while out_valid & !out_ready.
REQ-026 SHALL produce L in the range 0..MAN_W+1 for all EXP_W >= 4 and MAN_W >= 4 without truncation.

Reset
REQ-027 SHALL, on RST, clear both stage valid bits; out_valid = 0, Z = 0, OF = UF = ZR = 0 on the next cycle.
REQ-028 SHALL, on RST asserted mid-stream, discard in-flight operands and never emit them after reset.
REQ-029 SHALL drive in_ready = 1 during and after reset.

Verification
REQ-030 SHALL pass: M=25'h0800000, E=8'h7F, S=0, defaults -> Z=32'h3F800000, flags 0, two cycles later.
REQ-031 SHALL pass: M=25'h1000000, E=8'h7F -> Z=32'h40000000; M=25'h1000000, E=8'hFE -> Z=32'h7F800000, OF=1.
REQ-032 SHALL pass: M=25'h0000001, E=8'h7F, S=0 (L=23) -> Z=32'h34000000; the same M with E=8'h10, S=1 -> Z=32'h80000000, UF=1, ZR=1.
REQ-033 SHALL pass: M=0, S=1 -> Z=32'h80000000, ZR=1, UF=0.
REQ-034 SHALL pass: three back-to-back operands with out_ready low for 3 cycles -> in_ready low once full, Z held, all three delivered in order without loss or duplication.
REQ-035 SHALL pass: RST pulsed with two operands in flight -> out_valid=0 the next cycle and neither operand ever appears.
